// File: rtl/mii_repeater_tx.sv
`default_nettype none
// ============================================================================
// Module   : mii_repeater_tx
// Purpose  : Read side of the per-port repeater path. Pops nibbles from the
//            MII elastic buffer and drives a registered MII transmit port,
//            holding off buffer reads to enforce the inter-packet gap and
//            forwarding error/underflow nibbles as TX_ER.
// Options  : define MII_REPEATER_TX_JABBER_EN to cut off jabbering frames.
// Revision : 1.0 - initial release
// ============================================================================
module mii_repeater_tx #(
  parameter int IPG_NIBBLES    = 24,
  parameter int JABBER_NIBBLES = 131072
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ce,
  output logic       buf_ce,
  input  logic       buf_dv,
  input  logic       buf_er,
  input  logic [3:0] bufd,
  output logic       tx_ce,
  output logic       tx_en,
  output logic       tx_er,
  output logic [3:0] txd,
  output logic       ipg_stall,
  output logic       jabber
);

  localparam int               IPG_W    = $clog2(IPG_NIBBLES) + 1;
  // ipg_cnt + 1 == IPG_NIBBLES is tested as ipg_cnt == IPG_NIBBLES - 1
  localparam logic [IPG_W-1:0] IPG_LAST = IPG_W'(IPG_NIBBLES - 1);
  localparam logic [IPG_W-1:0] IPG_ONE  = IPG_W'(1);
  // With a one-nibble gap the idle emitted on frame exit is the whole gap
  localparam bit               IPG_HOLD = (IPG_NIBBLES > 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_IPG    = 2'd2;
`ifdef MII_REPEATER_TX_JABBER_EN
  localparam logic [1:0] ST_JABBER = 2'd3;

  localparam int               NIB_W    = $clog2(JABBER_NIBBLES) + 1;
  localparam logic [NIB_W-1:0] NIB_LAST = NIB_W'(JABBER_NIBBLES - 1);
  localparam logic [NIB_W-1:0] NIB_ONE  = NIB_W'(1);
  localparam logic [NIB_W-1:0] NIB_MAX  = '1;
`endif

  // Unsupported parameter values elaborate to nothing useful; flag them here
  if (IPG_NIBBLES < 1 || JABBER_NIBBLES < 2) begin : g_param_range_unsupported
  end

  logic [1:0]       state_q, state_d;
  logic [IPG_W-1:0] ipg_cnt_q, ipg_cnt_d;
`ifdef MII_REPEATER_TX_JABBER_EN
  logic [NIB_W-1:0] nib_cnt_q, nib_cnt_d;
`endif
  logic             tx_ce_q;
  logic             tx_en_q, tx_en_d;
  logic             tx_er_q, tx_er_d;
  logic [3:0]       txd_q, txd_d;

  // State and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ipg_cnt_q <= '0;
`ifdef MII_REPEATER_TX_JABBER_EN
      nib_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      ipg_cnt_q <= ipg_cnt_d;
`ifdef MII_REPEATER_TX_JABBER_EN
      nib_cnt_q <= nib_cnt_d;
`endif
    end
  end

  // Next-state and counter logic; everything advances only on a nibble strobe
  always_comb begin
    state_d   = state_q;
    ipg_cnt_d = ipg_cnt_q;
`ifdef MII_REPEATER_TX_JABBER_EN
    nib_cnt_d = nib_cnt_q;
`endif
    if (ce) begin
      case (state_q)
        ST_IDLE: begin
          if (buf_dv) begin
            state_d = ST_DATA;
`ifdef MII_REPEATER_TX_JABBER_EN
            nib_cnt_d = NIB_ONE;
`endif
          end
        end
        ST_DATA: begin
          if (buf_dv) begin
`ifdef MII_REPEATER_TX_JABBER_EN
            if (nib_cnt_q == NIB_LAST) begin
              state_d = ST_JABBER;
            end
            if (nib_cnt_q != NIB_MAX) begin
              nib_cnt_d = nib_cnt_q + 1'b1;
            end
`endif
          end else begin
            ipg_cnt_d = IPG_ONE;
            state_d   = IPG_HOLD ? ST_IPG : ST_IDLE;
          end
        end
        ST_IPG: begin
          ipg_cnt_d = ipg_cnt_q + 1'b1;
          if (ipg_cnt_q == IPG_LAST) begin
            state_d = ST_IDLE;
          end
        end
`ifdef MII_REPEATER_TX_JABBER_EN
        ST_JABBER: begin
          if (!buf_dv) begin
            ipg_cnt_d = IPG_ONE;
            state_d   = IPG_HOLD ? ST_IPG : ST_IDLE;
          end
        end
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode: next transmit nibble, buffer read strobe and status flags
  always_comb begin
    tx_en_d   = tx_en_q;
    tx_er_d   = tx_er_q;
    txd_d     = txd_q;
    buf_ce    = ce && (state_q != ST_IPG);
    ipg_stall = (state_q == ST_IPG) && buf_dv;
`ifdef MII_REPEATER_TX_JABBER_EN
    jabber    = (state_q == ST_JABBER);
`else
    jabber    = 1'b0;
`endif
    if (ce) begin
      tx_en_d = 1'b0;
      tx_er_d = 1'b0;
      txd_d   = 4'h0;
      if ((state_q == ST_IDLE || state_q == ST_DATA) && buf_dv) begin
        tx_en_d = 1'b1;
        tx_er_d = buf_er;
        txd_d   = bufd;
`ifdef MII_REPEATER_TX_JABBER_EN
        // The nibble that reaches the jabber limit is corrupted on the wire
        if (state_q == ST_DATA && nib_cnt_q == NIB_LAST) begin
          tx_er_d = 1'b1;
        end
`endif
      end
    end
  end

  // Registered MII transmit outputs, one clock behind the strobe cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ce_q <= 1'b0;
      tx_en_q <= 1'b0;
      tx_er_q <= 1'b0;
      txd_q   <= 4'h0;
    end else begin
      tx_ce_q <= ce;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
      txd_q   <= txd_d;
    end
  end

  assign tx_ce = tx_ce_q;
  assign tx_en = tx_en_q;
  assign tx_er = tx_er_q;
  assign txd   = txd_q;

endmodule
`default_nettype wire
